// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter
// and its seven-segment digit encoder.
package bcd_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low {g,f,e,d,c,b,a} patterns for the decimal digits 0..9.
    localparam logic [6:0] SEG_LUT [10] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_e;

    // Decimal digits needed for the largest WIDTH-bit value. This equals
    // ceil(width * log10(2)), because 2**width - 1 is never a power of ten.
    function automatic int min_digits(input int width);
        longint unsigned v;
        int              n;
        v = (64'd1 << width) - 64'd1;
        n = 0;
        while (v != 64'd0) begin
            n++;
            v = v / 64'd10;
        end
        return n;
    endfunction

endpackage

// File: rtl/bcd_seg7_lut.sv
// One BCD digit to active-low seven-segment pattern. Codes 10..15 are shown
// blank.
module bcd_seg7_lut
    import bcd_pkg::*;
(
    input  logic [3:0] code_i,
    output logic [6:0] seg_o
);

    // NOTE: the default assignment comes first, so every path assigns seg_o
    // and no latch is inferred.
    always_comb begin
        seg_o = SEG_BLANK;
        if (code_i <= 4'd9) begin
            seg_o = SEG_LUT[code_i];
        end
    end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter. It handles one input bit per clock and
// registers the BCD value and the active-low segment patterns for each digit.
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DIGITS   = 3,
    parameter int BLANK_LZ = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [7*DIGITS-1:0]   seg
);

    localparam int ACC_W = 4*DIGITS + WIDTH;
    localparam int CNT_W = $clog2(WIDTH + 1);

    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $error("bin_to_bcd_seq: WIDTH must be within 2..32");
    end
    if (DIGITS < min_digits(WIDTH)) begin : g_bad_digits
        $error("bin_to_bcd_seq: DIGITS too small for WIDTH");
    end

    state_e               state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [ACC_W-1:0]     acc_q;
    logic [4*DIGITS-1:0]  bcd_q;
    logic [7*DIGITS-1:0]  seg_q;

    logic [ACC_W-1:0]     acc_fix;
    logic [ACC_W-1:0]     acc_d;
    logic [4*DIGITS-1:0]  bcd_d;
    logic [7*DIGITS-1:0]  seg_raw;
    logic [7*DIGITS-1:0]  seg_d;
    logic                 accept;

    assign in_ready = !rst && ((state_q == IDLE) || (state_q == DONE && out_ready));
    assign accept   = in_valid && in_ready;

    // Working register is {bcd_acc, bin}. Correct each BCD digit, then shift.
    assign acc_fix[WIDTH-1:0] = acc_q[WIDTH-1:0];
    for (genvar d = 0; d < DIGITS; d++) begin : g_fix
        assign acc_fix[WIDTH + 4*d +: 4] = (acc_q[WIDTH + 4*d +: 4] >= 4'd5)
                                         ? acc_q[WIDTH + 4*d +: 4] + 4'd3
                                         : acc_q[WIDTH + 4*d +: 4];
    end
    assign acc_d = acc_fix << 1;
    assign bcd_d = acc_d[ACC_W-1:WIDTH];

    for (genvar i = 0; i < DIGITS; i++) begin : g_seg
        bcd_seg7_lut u_lut (
            .code_i (bcd_d[4*i +: 4]),
            .seg_o  (seg_raw[7*i +: 7])
        );
        if (BLANK_LZ != 0 && i > 0) begin : g_blank
            assign seg_d[7*i +: 7] = (bcd_d[4*DIGITS-1:4*i] == '0) ? SEG_BLANK
                                                                  : seg_raw[7*i +: 7];
        end else begin : g_show
            assign seg_d[7*i +: 7] = seg_raw[7*i +: 7];
        end
    end

    // NOTE: sequential state uses non-blocking assignments only. Each register
    // then reads its old value at the edge, whatever order the statements run in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            bcd_q   <= '0;
            seg_q   <= '1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        acc_q   <= {{(4*DIGITS){1'b0}}, in_data};
                        cnt_q   <= CNT_W'(WIDTH);
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        bcd_q   <= bcd_d;
                        seg_q   <= seg_d;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (accept) begin
                        acc_q   <= {{(4*DIGITS){1'b0}}, in_data};
                        cnt_q   <= CNT_W'(WIDTH);
                        state_q <= SHIFT;
                    end else if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_valid = (state_q == DONE);
    assign bcd       = bcd_q;
    assign seg       = seg_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq: three instances (8-bit shown, 8-bit with blanking,
// 16-bit) compared every cycle against a transaction-level decimal model.
module tb_bin_to_bcd_seq;

    localparam logic [6:0] SEG_TAB [10] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic        in_valid8  = 1'b0;
    logic [7:0]  in_data8   = '0;
    logic        out_ready8 = 1'b0;
    logic        in_valid16  = 1'b0;
    logic [15:0] in_data16   = '0;
    logic        out_ready16 = 1'b0;

    logic        in_ready_a, out_valid_a, in_ready_b, out_valid_b, in_ready_c, out_valid_c;
    logic [11:0] bcd_a, bcd_b;
    logic [20:0] seg_a, seg_b;
    logic [19:0] bcd_c;
    logic [34:0] seg_c;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    bin_to_bcd_seq #(.WIDTH(8), .DIGITS(3), .BLANK_LZ(0)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready_a),
        .in_data(in_data8), .out_valid(out_valid_a), .out_ready(out_ready8),
        .bcd(bcd_a), .seg(seg_a));

    bin_to_bcd_seq #(.WIDTH(8), .DIGITS(3), .BLANK_LZ(1)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready_b),
        .in_data(in_data8), .out_valid(out_valid_b), .out_ready(out_ready8),
        .bcd(bcd_b), .seg(seg_b));

    bin_to_bcd_seq #(.WIDTH(16), .DIGITS(5), .BLANK_LZ(0)) dut_c (
        .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready_c),
        .in_data(in_data16), .out_valid(out_valid_c), .out_ready(out_ready16),
        .bcd(bcd_c), .seg(seg_c));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model functions: the decimal digits of the value, plus the segment patterns.
    function automatic logic [63:0] exp_bcd(input longint unsigned v, input int digits);
        logic [63:0] r = '0;
        for (int i = 0; i < digits; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic logic [63:0] exp_seg(input bit has, input longint unsigned v,
                                            input int digits, input bit blank);
        logic [63:0]     r = '0;
        longint unsigned p = 1;
        if (!has) return (64'd1 << (7*digits)) - 64'd1;
        for (int i = 0; i < digits; i++) begin
            if (blank && i > 0 && v < p) r[7*i +: 7] = 7'h7F;
            else                         r[7*i +: 7] = SEG_TAB[int'((v / p) % 10)];
            p = p * 10;
        end
        return r;
    endfunction

    // Transaction model per group. A conversion becomes visible WIDTH edges
    // after it is accepted and stays visible until it is consumed.
    int              m_left [2] = '{0, 0};
    bit              m_out  [2] = '{0, 0};
    bit              m_has  [2] = '{0, 0};
    longint unsigned m_pend [2] = '{0, 0};
    longint unsigned m_res  [2] = '{0, 0};

    task automatic model_step(input int g, input bit v, input longint unsigned d,
                              input bit r, input int w);
        bit acc;
        acc = v && m_left[g] == 0 && (!m_out[g] || r);
        if (acc) begin
            m_out[g]  = 1'b0;
            m_left[g] = w;
            m_pend[g] = d;
        end else if (m_left[g] > 0) begin
            m_left[g]--;
            if (m_left[g] == 0) begin
                m_out[g] = 1'b1;
                m_has[g] = 1'b1;
                m_res[g] = m_pend[g];
            end
        end else if (m_out[g] && r) begin
            m_out[g] = 1'b0;
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int g = 0; g < 2; g++) begin
                m_left[g] = 0;
                m_out[g]  = 1'b0;
                m_has[g]  = 1'b0;
            end
        end else begin
            model_step(0, in_valid8, 64'(in_data8), out_ready8, 8);
            model_step(1, in_valid16, 64'(in_data16), out_ready16, 16);
        end
    end

    function automatic bit exp_ready(input int g, input bit r);
        return !rst && m_left[g] == 0 && (!m_out[g] || r);
    endfunction

    always @(negedge clk) begin
        check("a_valid", 64'(out_valid_a), 64'(m_out[0]));
        check("a_ready", 64'(in_ready_a), 64'(exp_ready(0, out_ready8)));
        check("a_bcd", 64'(bcd_a), m_has[0] ? exp_bcd(m_res[0], 3) : 64'd0);
        check("a_seg", 64'(seg_a), exp_seg(m_has[0], m_res[0], 3, 1'b0));
        check("b_valid", 64'(out_valid_b), 64'(m_out[0]));
        check("b_ready", 64'(in_ready_b), 64'(exp_ready(0, out_ready8)));
        check("b_bcd", 64'(bcd_b), m_has[0] ? exp_bcd(m_res[0], 3) : 64'd0);
        check("b_seg", 64'(seg_b), exp_seg(m_has[0], m_res[0], 3, 1'b1));
        check("c_valid", 64'(out_valid_c), 64'(m_out[1]));
        check("c_ready", 64'(in_ready_c), 64'(exp_ready(1, out_ready16)));
        check("c_bcd", 64'(bcd_c), m_has[1] ? exp_bcd(m_res[1], 5) : 64'd0);
        check("c_seg", 64'(seg_c), exp_seg(m_has[1], m_res[1], 5, 1'b0));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int g, input longint unsigned v);
        bit rdy;
        int n;
        n = 0;
        if (g == 0) begin in_valid8 = 1'b1;  in_data8  = v[7:0];  end
        else        begin in_valid16 = 1'b1; in_data16 = v[15:0]; end
        do begin
            @(negedge clk);
            rdy = (g == 0) ? in_ready_a : in_ready_c;
            tick();
            n++;
        end while (!rdy && n < 100);
        check("accept", 64'(rdy), 64'd1);
        if (g == 0) in_valid8 = 1'b0;
        else        in_valid16 = 1'b0;
    endtask

    task automatic wait_valid(input int g, output int edges);
        edges = 0;
        while (!((g == 0) ? out_valid_a : out_valid_c) && edges < 100) begin
            tick();
            edges++;
        end
    endtask

    task automatic release_result(input int g);
        if (g == 0) out_ready8 = 1'b1; else out_ready16 = 1'b1;
        tick();
        if (g == 0) out_ready8 = 1'b0; else out_ready16 = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int e;
        #1 rst = 1'b1;
        repeat (3) tick();
        check("rst_valid", 64'(out_valid_a), 64'd0);
        check("rst_ready", 64'(in_ready_a), 64'd0);
        check("rst_bcd", 64'(bcd_a), 64'd0);
        check("rst_seg", 64'(seg_a), 64'h1FFFFF);
        rst = 1'b0;
        tick();

        // 255 on the 8-bit pair
        send(0, 255);
        wait_valid(0, e);
        check("lat_255", 64'(e), 64'd8);
        check("bcd_255", 64'(bcd_a), 64'h255);
        check("seg_255", 64'(seg_a), 64'({7'h24, 7'h12, 7'h12}));
        check("segb_255", 64'(seg_b), 64'({7'h24, 7'h12, 7'h12}));

        // consume and accept 99 on the same edge
        out_ready8 = 1'b1; in_valid8 = 1'b1; in_data8 = 8'd99;
        @(negedge clk);
        check("b2b_ready", 64'(in_ready_a), 64'd1);
        tick();
        in_valid8 = 1'b0; out_ready8 = 1'b0;
        check("b2b_drop", 64'(out_valid_a), 64'd0);
        wait_valid(0, e);
        check("lat_99", 64'(e), 64'd8);
        check("bcd_99", 64'(bcd_a), 64'h099);
        check("segb_99", 64'(seg_b), 64'({7'h7F, 7'h10, 7'h10}));
        release_result(0);
        check("idle_valid", 64'(out_valid_a), 64'd0);
        check("idle_ready", 64'(in_ready_a), 64'd1);
        check("idle_hold", 64'(bcd_a), 64'h099);

        // back-pressure on 128 while in_valid pulses
        send(0, 128);
        wait_valid(0, e);
        for (int k = 0; k < 5; k++) begin
            in_valid8 = (k % 2 == 0); in_data8 = 8'd77;
            @(negedge clk);
            check("bp_ready", 64'(in_ready_a), 64'd0);
            tick();
            check("bp_bcd", 64'(bcd_a), 64'h128);
            check("bp_valid", 64'(out_valid_a), 64'd1);
        end
        in_valid8 = 1'b0;
        release_result(0);
        check("bp_release", 64'(out_valid_a), 64'd0);

        // leading-zero blanking
        send(0, 0);
        wait_valid(0, e);
        check("bcdb_0", 64'(bcd_b), 64'd0);
        check("segb_0", 64'(seg_b), 64'({7'h7F, 7'h7F, 7'h40}));
        check("sega_0", 64'(seg_a), 64'({7'h40, 7'h40, 7'h40}));
        release_result(0);
        send(0, 7);
        wait_valid(0, e);
        check("segb_7", 64'(seg_b), 64'({7'h7F, 7'h7F, 7'h78}));
        release_result(0);

        // reset four edges into converting 200
        send(0, 200);
        repeat (3) tick();
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 64'(out_valid_a), 64'd0);
        check("mid_rst_bcd", 64'(bcd_a), 64'd0);
        check("mid_rst_seg", 64'(seg_a), 64'h1FFFFF);
        check("mid_rst_ready", 64'(in_ready_a), 64'd0);
        tick();
        rst = 1'b0;
        tick();
        send(0, 42);
        wait_valid(0, e);
        check("bcd_42", 64'(bcd_a), 64'h042);
        release_result(0);

        // 16-bit instance
        send(1, 65535);
        wait_valid(1, e);
        check("lat_65535", 64'(e), 64'd16);
        check("bcd_65535", 64'(bcd_c), 64'h65535);
        release_result(1);
        send(1, 1000);
        wait_valid(1, e);
        check("bcd_1000", 64'(bcd_c), 64'h01000);
        check("seg_1000", 64'(seg_c), 64'({7'h40, 7'h79, 7'h40, 7'h40, 7'h40}));
        release_result(1);

        // random traffic, including the 0 and all-ones boundaries and rare resets
        for (int k = 0; k < 3000; k++) begin
            in_valid8   = 1'($urandom_range(0, 1));
            in_valid16  = 1'($urandom_range(0, 1));
            out_ready8  = 1'($urandom_range(0, 1));
            out_ready16 = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 7))
                0:       begin in_data8 = 8'd0;   in_data16 = 16'd0;     end
                1:       begin in_data8 = 8'd255; in_data16 = 16'hFFFF;  end
                default: begin in_data8 = 8'($urandom); in_data16 = 16'($urandom); end
            endcase
            if ($urandom_range(0, 399) == 0) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
            end
            tick();
        end
        in_valid8 = 1'b0; in_valid16 = 1'b0;
        out_ready8 = 1'b1; out_ready16 = 1'b1;
        repeat (40) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
